// File: rtl/pal_test_pkg.sv
// Shared types, constants and MISR step function for the PAL vector sweep self-test.
// Pure definitions: no latency, no handshake.
package pal_test_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} sweep_state_t;

  localparam logic [15:0] MISR_POLY   = 16'h1021;
  localparam logic [15:0] MISR_SEED   = 16'hFFFF;
  localparam int          NUM_VECTORS = 16;
  localparam int          RESP_W      = 2;
  localparam int          VEC_W       = 4;
  localparam int          MAP_W       = NUM_VECTORS * RESP_W;

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [RESP_W-1:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {{(16-RESP_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/pal_vector_sweep_if.sv
// Stimulus/response bundle between the sweep engine and its controller + PAL.
// Plain wires; the sweep engine owns every output and registers it.
interface pal_vector_sweep_if;
  import pal_test_pkg::*;

  logic              start;
  logic              abort;
  logic [VEC_W-1:0]  pal_in;
  logic [RESP_W-1:0] pal_out;
  logic              busy;
  logic              done;
  logic [MAP_W-1:0]  resp_map;
  logic [15:0]       signature;
  logic              pass;

  modport master (
    output start, abort, pal_out,
    input  pal_in, busy, done, resp_map, signature, pass
  );

  modport slave (
    input  start, abort, pal_out,
    output pal_in, busy, done, resp_map, signature, pass
  );

endinterface

// File: rtl/pal_misr16.sv
// 16-bit MISR folding one 2-bit response per enabled cycle; clear reloads the seed.
// One-cycle update latency, no backpressure.
module pal_misr16
  import pal_test_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [15:0]       sig
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = misr_step(sig_q, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/pal_vector_sweep.sv
// Sweeps all 16 PAL input vectors, captures each response into a map and a MISR, reports pass/fail.
// Sweep takes 16*(SETTLE_CYCLES+1)+1 cycles from start to done; start is ignored while busy.
module pal_vector_sweep
  import pal_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED_SIG  = 16'h0000
)(
  input logic               clk,
  input logic               rst,
  pal_vector_sweep_if.slave sw
);

  if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $fatal(1, "SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

  sweep_state_t     state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [7:0]       settle_q, settle_d;
  logic [MAP_W-1:0] work_q, work_d;
  logic [MAP_W-1:0] resp_map_q, resp_map_d;
  logic [15:0]      signature_q, signature_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [VEC_W-1:0] pal_in_q, pal_in_d;

  logic             misr_clear;
  logic             misr_en;
  logic [15:0]      misr_sig;
  logic [15:0]      final_sig;

  pal_misr16 u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (misr_clear),
    .en    (misr_en),
    .din   (sw.pal_out),
    .sig   (misr_sig)
  );

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    work_d      = work_q;
    resp_map_d  = resp_map_q;
    signature_d = signature_q;
    pass_d      = pass_q;
    misr_clear  = 1'b0;
    misr_en     = 1'b0;
    final_sig   = misr_step(misr_sig, sw.pal_out);

    case (state_q)
      IDLE: begin
        if (sw.start) begin
          state_d    = DRIVE;
          vec_d      = '0;
          settle_d   = '0;
          work_d     = '0;
          pass_d     = 1'b0;
          misr_clear = 1'b1;
        end
      end
      DRIVE: begin
        if (sw.abort) begin
          state_d  = IDLE;
          vec_d    = '0;
          settle_d = '0;
          pass_d   = 1'b0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = CAPTURE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      CAPTURE: begin
        if (sw.abort) begin
          state_d  = IDLE;
          vec_d    = '0;
          settle_d = '0;
          pass_d   = 1'b0;
        end else begin
          misr_en = 1'b1;
          work_d[{vec_q, 1'b0} +: RESP_W] = sw.pal_out;
          if (vec_q == LAST_VEC) begin
            // Results land on the edge into DONE so they are valid during the done pulse.
            state_d     = DONE;
            resp_map_d  = work_d;
            signature_d = final_sig;
            pass_d      = (final_sig == EXPECTED_SIG);
          end else begin
            state_d  = DRIVE;
            vec_d    = vec_q + 1'b1;
            settle_d = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        vec_d   = '0;
      end
      default: begin
        state_d = IDLE;
        vec_d   = '0;
      end
    endcase

    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    pal_in_d = (state_d == DRIVE || state_d == CAPTURE) ? vec_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      settle_q    <= '0;
      work_q      <= '0;
      resp_map_q  <= '0;
      signature_q <= '0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pal_in_q    <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      work_q      <= work_d;
      resp_map_q  <= resp_map_d;
      signature_q <= signature_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pal_in_q    <= pal_in_d;
    end
  end

  assign sw.pal_in    = pal_in_q;
  assign sw.busy      = busy_q;
  assign sw.done      = done_q;
  assign sw.resp_map  = resp_map_q;
  assign sw.signature = signature_q;
  assign sw.pass      = pass_q;

endmodule
